// File: rtl/pe_mac_sequencer_if.sv
// Operand, PE and result bundle between pe_mac_sequencer (master) and its environment (slave).
// Handshake rule for op_* and res_*: a transfer happens on a rising clk edge where valid and
// ready are both 1; valid, once raised, holds its payload stable until that edge.
interface pe_mac_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
);
   logic                 start;
   logic [LEN_W-1:0]     len;
   logic [2*WIDTH-1:0]   bias;
   logic                 busy;
   logic                 op_vld;
   logic                 op_rdy;
   logic [WIDTH-1:0]     op_data;
   logic [WIDTH-1:0]     op_weight;
   logic [WIDTH-1:0]     pe_data;
   logic [WIDTH-1:0]     pe_weight;
   logic [2*WIDTH-1:0]   pe_psum;
   logic                 pe_data_update;
   logic                 pe_weight_update;
   logic                 pe_psum_update;
   logic [2*WIDTH-1:0]   pe_out_psum;
   logic                 pe_out_psum_vld;
   logic                 res_vld;
   logic                 res_rdy;
   logic [2*WIDTH-1:0]   res_psum;
   logic                 res_err;

   modport master (
      input  start, len, bias, op_vld, op_data, op_weight, pe_out_psum, pe_out_psum_vld, res_rdy,
      output busy, op_rdy, pe_data, pe_weight, pe_psum, pe_data_update, pe_weight_update,
             pe_psum_update, res_vld, res_psum, res_err
   );

   modport slave (
      output start, len, bias, op_vld, op_data, op_weight, pe_out_psum, pe_out_psum_vld, res_rdy,
      input  busy, op_rdy, pe_data, pe_weight, pe_psum, pe_data_update, pe_weight_update,
             pe_psum_update, res_vld, res_psum, res_err
   );
endinterface

// File: rtl/pe_mac_sequencer.sv
// Drives one PE through LEN multiply-accumulate terms, feeding each returned psum back in,
// and returns the accumulated psum (or a timeout error) on a valid/ready result port.
module pe_mac_sequencer #(
   parameter int WIDTH   = 8,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                rst,
   pe_mac_sequencer_if.master  bus,
   output logic [2:0]          fsm_state
);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]         state;
   logic [2:0]         state_nxt;
   logic [LEN_W-1:0]   term_cnt;
   logic [2*WIDTH-1:0] acc;
   logic [TW-1:0]      tmo_cnt;
   logic               op_fire;
   logic               tmo_hit;

   assign op_fire   = bus.op_vld & bus.op_rdy;
   // The count reaches TIMEOUT-1 on this cycle's increment, so DONE lands TIMEOUT cycles after ISSUE.
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 2));
   assign fsm_state = state;
   assign bus.res_psum = acc;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : FETCH;
         FETCH: if (op_fire) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (bus.pe_out_psum_vld)
               state_nxt = (term_cnt == LEN_W'(1)) ? DONE : FETCH;
            else if (tmo_hit)
               state_nxt = DONE;
         end
         DONE:  if (bus.res_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status and strobe outputs are decoded from the next state so they are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= IDLE;
         term_cnt             <= '0;
         acc                  <= '0;
         tmo_cnt              <= '0;
         bus.busy             <= 1'b0;
         bus.op_rdy           <= 1'b0;
         bus.pe_data          <= '0;
         bus.pe_weight        <= '0;
         bus.pe_psum          <= '0;
         bus.pe_data_update   <= 1'b0;
         bus.pe_weight_update <= 1'b0;
         bus.pe_psum_update   <= 1'b0;
         bus.res_vld          <= 1'b0;
         bus.res_err          <= 1'b0;
      end else begin
         state                <= state_nxt;
         bus.busy             <= (state_nxt != IDLE);
         bus.op_rdy           <= (state_nxt == FETCH);
         bus.pe_data_update   <= (state_nxt == ISSUE);
         bus.pe_weight_update <= (state_nxt == ISSUE);
         bus.pe_psum_update   <= (state_nxt == ISSUE);
         bus.res_vld          <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  term_cnt    <= bus.len;
                  acc         <= bus.bias;
                  bus.res_err <= 1'b0;
               end
            end
            FETCH: begin
               if (op_fire) begin
                  bus.pe_data   <= bus.op_data;
                  bus.pe_weight <= bus.op_weight;
                  bus.pe_psum   <= acc;
               end
            end
            ISSUE: tmo_cnt <= '0;
            WAIT: begin
               if (bus.pe_out_psum_vld) begin
                  acc      <= bus.pe_out_psum;
                  term_cnt <= term_cnt - LEN_W'(1);
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (tmo_hit) bus.res_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: behavioural PE, operand/result drivers, and a scoreboard whose
// expected results come from bias + sum(data*weight) mod 2^16 computed at job issue.
module tb_pe_mac_sequencer;
   localparam int WIDTH   = 8;
   localparam int LEN_W   = 8;
   localparam int TIMEOUT = 16;
   localparam int PW      = 2 * WIDTH;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] fsm_state;
   int         cyc = 0;

   pe_mac_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   pe_mac_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [PW:0]  exp_q[$];
   logic [WIDTH-1:0] job_d[$];
   logic [WIDTH-1:0] job_w[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural PE ----------------
   bit            pe_en = 1'b1;
   int            pe_lat = 4;
   int            strobe_cnt = 0;
   int            issue_cyc = 0;
   int            pend = 0;
   logic [PW-1:0] pend_val;

   initial begin
      bus.pe_out_psum_vld = 1'b0;
      bus.pe_out_psum     = '0;
      forever begin
         @(negedge clk);
         bus.pe_out_psum_vld = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.pe_out_psum_vld = 1'b1;
               bus.pe_out_psum     = pend_val;
            end
         end
         if (bus.pe_data_update) begin
            strobe_cnt++;
            issue_cyc = cyc;
            check("strobe_align", 32'({bus.pe_weight_update, bus.pe_psum_update}), 32'd3);
            if (pe_en) begin
               pend_val = bus.pe_psum + PW'(bus.pe_data) * PW'(bus.pe_weight);
               pend     = pe_lat;
            end
         end
      end
   end

   // ---------------- result monitor ----------------
   logic          vld_prev = 1'b0;
   logic          rdy_prev = 1'b0;
   logic [PW-1:0] psum_prev = '0;
   logic          err_prev = 1'b0;
   int            vld_rise_cyc = 0;
   int            op_rdy_cnt = 0;

   initial begin
      logic [PW:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (bus.op_rdy) op_rdy_cnt++;
         if (bus.res_vld) begin
            if (!vld_prev) vld_rise_cyc = cyc;
            else if (!rdy_prev) begin
               check("stall_psum", 32'(bus.res_psum), 32'(psum_prev));
               check("stall_err", 32'(bus.res_err), 32'(err_prev));
            end
            if (bus.res_rdy) begin
               if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("res_psum", 32'(bus.res_psum), 32'(e[PW-1:0]));
                  check("res_err", 32'(bus.res_err), 32'(e[PW]));
               end
            end
         end
         vld_prev  = bus.res_vld;
         rdy_prev  = bus.res_rdy;
         psum_prev = bus.res_psum;
         err_prev  = bus.res_err;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill_random(input int len);
      job_d.delete();
      job_w.delete();
      for (int i = 0; i < len; i++) begin
         job_d.push_back(WIDTH'($urandom_range(0, 255)));
         job_w.push_back(WIDTH'($urandom_range(0, 255)));
      end
   endtask

   task automatic feed_pair(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] w);
      int waited;
      bus.op_vld    = 1'b1;
      bus.op_data   = d;
      bus.op_weight = w;
      waited = 0;
      while (!bus.op_rdy && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) check("op_rdy_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.op_vld    = 1'b0;
      bus.op_data   = WIDTH'($urandom);
      bus.op_weight = WIDTH'($urandom);
   endtask

   task automatic pulse_start(input int len, input logic [PW-1:0] bias);
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = LEN_W'(len);
      bus.bias  = bias;
      @(negedge clk);
      bus.start = 1'b0;
      bus.len   = LEN_W'($urandom);
      bus.bias  = PW'($urandom);
   endtask

   task automatic run_job(input int len, input logic [PW-1:0] bias, input int min_gap,
                          input int max_gap, input int stall, input bit busy_starts,
                          input bit timeout_mode);
      logic [PW-1:0] ref_sum;
      int feeds, s0, r0, waited, gap;
      ref_sum = bias;
      for (int i = 0; i < len; i++) ref_sum = ref_sum + PW'(job_d[i]) * PW'(job_w[i]);
      feeds = timeout_mode ? 1 : len;
      exp_q.push_back(timeout_mode ? {1'b1, bias} : {1'b0, ref_sum});
      s0          = strobe_cnt;
      r0          = op_rdy_cnt;
      pe_en       = !timeout_mode;
      bus.res_rdy = (stall == 0);
      pulse_start(len, bias);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      if (len == 0) check("len0_vld_latency", 32'(bus.res_vld), 32'd1);
      for (int k = 0; k < feeds; k++) begin
         gap = $urandom_range(min_gap, max_gap);
         repeat (gap) begin
            if (busy_starts) begin
               bus.start = 1'b1;
               bus.len   = LEN_W'($urandom_range(1, 9));
               bus.bias  = PW'($urandom);
            end
            @(negedge clk);
            bus.start = 1'b0;
            check("busy_in_job", 32'(bus.busy), 32'd1);
         end
         feed_pair(job_d[k], job_w[k]);
      end
      waited = 0;
      while (!bus.res_vld && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 500) check("res_vld_timeout", 32'd0, 32'd1);
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         bus.res_rdy = 1'b1;
      end
      waited = 0;
      while (bus.busy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("idle_after_job", 32'(bus.busy), 32'd0);
      check("strobe_count", 32'(strobe_cnt - s0), 32'(feeds));
      if (len == 0) check("len0_op_rdy_cycles", 32'(op_rdy_cnt - r0), 32'd0);
      if (timeout_mode) check("timeout_latency", 32'(vld_rise_cyc - issue_cyc), 32'(TIMEOUT));
      pe_en = 1'b1;
   endtask

   task automatic reset_mid_job();
      int s0, waited;
      s0 = strobe_cnt;
      pe_lat = 4;
      fill_random(2);
      pulse_start(2, PW'($urandom));
      feed_pair(job_d[0], job_w[0]);
      feed_pair(job_d[1], job_w[1]);
      waited = 0;
      while (strobe_cnt < s0 + 2 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("second_issue_seen", 32'(strobe_cnt - s0), 32'd2);
      @(negedge clk);
      check("in_wait_before_reset", 32'(fsm_state), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_op_rdy", 32'(bus.op_rdy), 32'd0);
      check("rst_strobes", 32'({bus.pe_data_update, bus.pe_weight_update, bus.pe_psum_update}), 32'd0);
      check("rst_pe_data", 32'({bus.pe_data, bus.pe_weight}), 32'd0);
      check("rst_pe_psum", 32'(bus.pe_psum), 32'd0);
      check("rst_res", 32'({bus.res_vld, bus.res_err, bus.res_psum}), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.bias      = '0;
      bus.op_vld    = 1'b0;
      bus.op_data   = '0;
      bus.op_weight = '0;
      bus.res_rdy   = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_res_vld", 32'(bus.res_vld), 32'd0);
      check("reset_res_psum", 32'(bus.res_psum), 32'd0);
      check("reset_op_rdy", 32'(bus.op_rdy), 32'd0);
      check("reset_state", 32'(fsm_state), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_release", 32'({bus.busy, bus.op_rdy, bus.pe_data_update}), 32'd0);

      // T1: 10 + 1*2 + 3*4 + 5*6 = 54
      pe_lat = 4;
      job_d = '{8'd1, 8'd3, 8'd5};
      job_w = '{8'd2, 8'd4, 8'd6};
      run_job(3, 16'd10, 0, 0, 0, 1'b0, 1'b0);
      // T2: empty job returns bias
      job_d.delete();
      job_w.delete();
      run_job(0, 16'd7, 0, 0, 0, 1'b0, 1'b0);
      // T3: wrap-around, 2*65025 mod 65536 = 64514
      job_d = '{8'd255, 8'd255};
      job_w = '{8'd255, 8'd255};
      run_job(2, 16'd0, 0, 0, 0, 1'b0, 1'b0);
      // T4: T1 with operand gaps, stalled result and stray starts
      job_d = '{8'd1, 8'd3, 8'd5};
      job_w = '{8'd2, 8'd4, 8'd6};
      run_job(3, 16'd10, 5, 5, 10, 1'b1, 1'b0);
      // T5: PE never answers
      fill_random(3);
      run_job(3, 16'h1234, 0, 2, 0, 1'b0, 1'b1);
      // T6: reset during WAIT of term 2, then 1 + 2*3 = 7
      reset_mid_job();
      job_d = '{8'd2};
      job_w = '{8'd3};
      run_job(1, 16'd1, 0, 0, 0, 1'b0, 1'b0);

      for (int j = 0; j < 25; j++) begin
         int len;
         len    = $urandom_range(0, 6);
         pe_lat = $urandom_range(1, 6);
         fill_random(len);
         run_job(len, PW'($urandom), 0, 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (3) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #300000;
      check("watchdog", 32'd0, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
